blueprint_snd_out: RTL

Audio back-end for the Blue Print core, sitting directly downstream of the sound board model. It consumes the signed 16-bit mixed AY output, which changes at the master clock rate. It box-car decimates that stream to exactly 48 kHz, applies a one-pole low-pass standing in for the PCB output RC, then a ramped master gain with mute/pause fade and saturation. It presents one registered sample per output period with a strobe for the framework audio path.

---
 rtl/blueprint_snd_pkg.sv | 36 +++
 rtl/blueprint_snd_lpf.sv | 50 +++++
 rtl/blueprint_snd_out.sv | 121 ++++++++++++
 3 files changed

// File: rtl/blueprint_snd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : blueprint_snd_pkg
// Purpose  : Shared widths, fixed-point constants and the output saturator.
// Revision : 1.0
// ============================================================================
package blueprint_snd_pkg;

    localparam int DEC_LOG2_DEF = 10;
    localparam int GAIN_FRAC    = 3;
    localparam int LPF_FRAC     = 4;
    localparam int GAIN_MAX     = 16;

    localparam int SAMPLE_W = 16;
    localparam int GAIN_W   = $clog2(GAIN_MAX + 1);
    localparam int PROD_W   = SAMPLE_W + GAIN_W;
    localparam int SCALED_W = PROD_W - GAIN_FRAC;

    localparam logic signed [SCALED_W-1:0] Q_MAX = SCALED_W'(32767);
    localparam logic signed [SCALED_W-1:0] Q_MIN = SCALED_W'(-32768);

    // Clamp the gain-scaled product into the signed 16-bit output range.
    function automatic logic [SAMPLE_W-1:0] sat16(input logic signed [SCALED_W-1:0] v);
        logic [SAMPLE_W-1:0] r;
        if (v > Q_MAX) begin
            r = 16'h7fff;
        end else if (v < Q_MIN) begin
            r = 16'h8000;
        end else begin
            r = v[SAMPLE_W-1:0];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/blueprint_snd_lpf.sv
`default_nettype none
// ============================================================================
// Module   : blueprint_snd_lpf
// Purpose  : One-pole IIR low-pass, alpha = 2^-FILT_SHIFT, 16.4 fixed-point state.
// Revision : 1.0
// ============================================================================
module blueprint_snd_lpf
    import blueprint_snd_pkg::*;
#(
    parameter int FILT_SHIFT = 2
) (
    input  logic                clk_49m,
    input  logic                reset,
    input  logic                en,
    input  logic [SAMPLE_W-1:0] x,
    output logic [SAMPLE_W-1:0] y
);
    localparam int S_W = SAMPLE_W + LPF_FRAC;

    logic [S_W-1:0]        s_q;
    logic [S_W-1:0]        s_d;
    logic signed [S_W:0]   x_ext;
    logic signed [S_W:0]   diff;
    logic signed [S_W:0]   step;
    logic [S_W:0]          sum;

    // One guard bit keeps (x - s) exact; the update itself never leaves the 20-bit range.
    always_comb begin
        x_ext = {x[SAMPLE_W-1], x, {LPF_FRAC{1'b0}}};
        diff  = x_ext - {s_q[S_W-1], s_q};
        step  = diff >>> FILT_SHIFT;
        sum   = {s_q[S_W-1], s_q} + step;
        s_d   = s_q;
        if (en) begin
            s_d = sum[S_W-1:0];
        end
    end

    always_ff @(posedge clk_49m or negedge reset) begin
        if (!reset) begin
            s_q <= '0;
        end else begin
            s_q <= s_d;
        end
    end

    assign y = s_q[S_W-1:LPF_FRAC];

endmodule
`default_nettype wire

// File: rtl/blueprint_snd_out.sv
`default_nettype none
// ============================================================================
// Module   : blueprint_snd_out
// Purpose  : Box-car decimator, output LPF, ramped master gain and saturator.
// Revision : 1.0
// ============================================================================
module blueprint_snd_out
    import blueprint_snd_pkg::*;
#(
    parameter int DEC_LOG2   = DEC_LOG2_DEF,
    parameter int FILT_SHIFT = 2
) (
    input  logic        clk_49m,
    input  logic        reset,
    input  logic [15:0] sound_in,
    input  logic [3:0]  volume,
    input  logic        mute,
    input  logic        pause,
    output logic [15:0] sample_o,
    output logic        sample_stb
);
    localparam int ACC_W = SAMPLE_W + DEC_LOG2;

    logic [DEC_LOG2-1:0] ph_q;
    logic [DEC_LOG2-1:0] ph_d;
    logic [ACC_W-1:0]    acc_q;
    logic [ACC_W-1:0]    acc_d;
    logic [ACC_W-1:0]    acc_sum;
    logic [SAMPLE_W-1:0] avg_q;
    logic [SAMPLE_W-1:0] avg_d;
    logic                avg_vld_q;
    logic                avg_vld_d;
    logic                s_vld_q;
    logic                s_vld_d;
    logic [GAIN_W-1:0]   g_q;
    logic [GAIN_W-1:0]   g_d;
    logic [GAIN_W-1:0]   g_tgt;
    logic [PROD_W-1:0]   prod_q;
    logic [PROD_W-1:0]   prod_d;
    logic                prod_vld_q;
    logic                prod_vld_d;
    logic [SAMPLE_W-1:0] sample_q;
    logic [SAMPLE_W-1:0] sample_d;
    logic                stb_q;
    logic                stb_d;
    logic [SAMPLE_W-1:0] lpf_y;
    logic                ph_term;

    blueprint_snd_lpf #(
        .FILT_SHIFT (FILT_SHIFT)
    ) u_lpf (
        .clk_49m (clk_49m),
        .reset   (reset),
        .en      (avg_vld_q),
        .x       (avg_q),
        .y       (lpf_y)
    );

    // The terminal sample is folded into the average directly so the
    // accumulator can restart from zero on the same clock.
    always_comb begin
        ph_term   = (ph_q == {DEC_LOG2{1'b1}});
        ph_d      = ph_q + DEC_LOG2'(1);
        acc_sum   = acc_q + {{DEC_LOG2{sound_in[SAMPLE_W-1]}}, sound_in};
        acc_d     = ph_term ? '0 : acc_sum;
        avg_vld_d = ph_term;
        avg_d     = ph_term ? acc_sum[ACC_W-1:DEC_LOG2] : avg_q;
    end

    // Gain steps once per sample, on the same clock the filter state advances.
    always_comb begin
        g_tgt = (mute | pause) ? '0 : GAIN_W'(volume) + GAIN_W'(1);
        g_d   = g_q;
        if (avg_vld_q) begin
            if (g_q < g_tgt) begin
                g_d = g_q + GAIN_W'(1);
            end else if (g_q > g_tgt) begin
                g_d = g_q - GAIN_W'(1);
            end
        end
        s_vld_d = avg_vld_q;
    end

    always_comb begin
        prod_d     = {{GAIN_W{lpf_y[SAMPLE_W-1]}}, lpf_y} * {{SAMPLE_W{1'b0}}, g_q};
        prod_vld_d = s_vld_q;
        stb_d      = prod_vld_q;
        sample_d   = prod_vld_q ? sat16(prod_q[PROD_W-1:GAIN_FRAC]) : sample_q;
    end

    always_ff @(posedge clk_49m or negedge reset) begin
        if (!reset) begin
            ph_q       <= '0;
            acc_q      <= '0;
            avg_q      <= '0;
            avg_vld_q  <= 1'b0;
            s_vld_q    <= 1'b0;
            g_q        <= '0;
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
            sample_q   <= '0;
            stb_q      <= 1'b0;
        end else begin
            ph_q       <= ph_d;
            acc_q      <= acc_d;
            avg_q      <= avg_d;
            avg_vld_q  <= avg_vld_d;
            s_vld_q    <= s_vld_d;
            g_q        <= g_d;
            prod_q     <= prod_d;
            prod_vld_q <= prod_vld_d;
            sample_q   <= sample_d;
            stb_q      <= stb_d;
        end
    end

    assign sample_o   = sample_q;
    assign sample_stb = stb_q;

endmodule
`default_nettype wire
